// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
package sw_debounce_pkg;

  localparam int unsigned SYNC_STAGES           = 2;
  localparam int unsigned DEFAULT_STABLE_CYCLES = 50000;

  // Stability counter width; a 1-cycle window still needs one flop.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, clean flop and change strobe.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned StableCycles = DEFAULT_STABLE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic valid_i,
  output logic clean_o,
  output logic changed_o,
  output logic set_o
);

  localparam int unsigned   CntW   = cnt_width(StableCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(StableCycles - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   changed_q, changed_d;
  logic                   sync2;
  logic                   accept;

  assign sync2 = sync_q[SYNC_STAGES-1];

  // Any return to the clean level zeroes the count: no partial credit for bounces.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    accept  = 1'b0;
    if (sync2 != clean_q) begin
      if (cnt_q == CntMax) begin
        accept  = 1'b1;
        clean_d = sync2;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    changed_d = accept & valid_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      changed_q <= changed_d;
    end
  end

  assign clean_o   = clean_q;
  assign changed_o = changed_q;
  // Same-edge set request for the sticky register in the parent.
  assign set_o     = changed_d;

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner for the PIO switch input. Optional sticky change
// register is enabled with the SW_DEBOUNCE_STICKY_EN macro.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] sw_raw_in,
  output logic [WIDTH-1:0] sw_clean_out,
  output logic [WIDTH-1:0] sw_changed_out,
  output logic             sw_valid_out,
  output logic [WIDTH-1:0] sw_sticky_out,
  input  logic [WIDTH-1:0] sw_clear_in
);

  localparam int unsigned     SetW      = $clog2(STABLE_CYCLES + 3);
  localparam logic [SetW-1:0] SettleMax = SetW'(STABLE_CYCLES + 2);

  logic [SetW-1:0]  settle_q, settle_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] set_req;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .StableCycles(STABLE_CYCLES)
    ) u_bit (
      .clk_i    (clk_clk),
      .rst_ni   (reset_reset_n),
      .raw_i    (sw_raw_in[i]),
      .valid_i  (valid_q),
      .clean_o  (sw_clean_out[i]),
      .changed_o(sw_changed_out[i]),
      .set_o    (set_req[i])
    );
  end

  // Settle counter parks at its terminal value once valid is up.
  always_comb begin
    settle_d = settle_q;
    valid_d  = valid_q;
    if (settle_q == SettleMax) begin
      valid_d = 1'b1;
    end else begin
      settle_d = settle_q + SetW'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      settle_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      settle_q <= settle_d;
      valid_q  <= valid_d;
    end
  end

  assign sw_valid_out = valid_q;

`ifdef SW_DEBOUNCE_STICKY_EN
  logic [WIDTH-1:0] sticky_q, sticky_d;

  // Set wins over a coincident clear.
  always_comb begin
    sticky_d = (sticky_q & ~sw_clear_in) | set_req;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sw_sticky_out = sticky_q;
`else
  logic unused_sticky;
  assign unused_sticky = ^{sw_clear_in, set_req};
  assign sw_sticky_out = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with WIDTH=8, STABLE_CYCLES=4.
module tb_sw_debounce;

  localparam int unsigned W = 8;
  localparam int unsigned S = 4;
`ifdef SW_DEBOUNCE_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic         clk_clk;
  logic         reset_reset_n;
  logic [W-1:0] sw_raw_in;
  logic [W-1:0] sw_clean_out;
  logic [W-1:0] sw_changed_out;
  logic         sw_valid_out;
  logic [W-1:0] sw_sticky_out;
  logic [W-1:0] sw_clear_in;

  sw_debounce #(
    .WIDTH        (W),
    .STABLE_CYCLES(S)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .sw_raw_in     (sw_raw_in),
    .sw_clean_out  (sw_clean_out),
    .sw_changed_out(sw_changed_out),
    .sw_valid_out  (sw_valid_out),
    .sw_sticky_out (sw_sticky_out),
    .sw_clear_in   (sw_clear_in)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  typedef struct packed {
    logic [W-1:0] clean;
    logic [W-1:0] changed;
    logic [W-1:0] sticky;
    logic         valid;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [W-1:0] m_s1, m_s2, m_clean, m_changed, m_sticky;
  int           m_cnt[W];
  int           m_settle;
  logic         m_valid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_clean = '0; m_changed = '0; m_sticky = '0;
    for (int i = 0; i < W; i++) m_cnt[i] = 0;
    m_settle = 0;
    m_valid  = 1'b0;
  endtask

  task automatic model_step(input logic [W-1:0] raw, input logic [W-1:0] clr);
    exp_t         e;
    logic [W-1:0] n_clean, n_changed;
    int           n_cnt[W];
    logic         n_valid;
    if (!reset_reset_n) begin
      model_reset();
    end else begin
      n_clean   = m_clean;
      n_changed = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_clean[i]) begin
          n_cnt[i] = 0;
        end else if (m_cnt[i] == S - 1) begin
          n_cnt[i]     = 0;
          n_clean[i]   = m_s2[i];
          n_changed[i] = m_valid;
        end else begin
          n_cnt[i] = m_cnt[i] + 1;
        end
      end
      n_valid = m_valid | (m_settle == S + 2);
      if (!m_valid) m_settle++;
      m_sticky  = STICKY ? (n_changed | (m_sticky & ~clr)) : '0;
      m_valid   = n_valid;
      m_cnt     = n_cnt;
      m_clean   = n_clean;
      m_changed = n_changed;
      m_s2      = m_s1;
      m_s1      = raw;
    end
    e.clean   = m_clean;
    e.changed = m_changed;
    e.sticky  = m_sticky;
    e.valid   = m_valid;
    sb_q.push_back(e);
  endtask

  // Drive on the falling edge, model the next rising edge, compare 1 ns after it.
  task automatic cycle(input logic [W-1:0] raw, input logic [W-1:0] clr);
    exp_t e;
    @(negedge clk_clk);
    sw_raw_in   = raw;
    sw_clear_in = clr;
    model_step(raw, clr);
    @(posedge clk_clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("clean",   32'(sw_clean_out),   32'(e.clean));
      check_eq("changed", 32'(sw_changed_out), 32'(e.changed));
      check_eq("valid",   32'(sw_valid_out),   32'(e.valid));
      check_eq("sticky",  32'(sw_sticky_out),  32'(e.sticky));
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_clean"},   32'(sw_clean_out),   32'd0);
    check_eq({tag, "_changed"}, 32'(sw_changed_out), 32'd0);
    check_eq({tag, "_valid"},   32'(sw_valid_out),   32'd0);
    check_eq({tag, "_sticky"},  32'(sw_sticky_out),  32'd0);
  endtask

  initial begin
    int          strobes;
    int          strobe_at;
    logic [W-1:0] raw;

    reset_reset_n = 1'b0;
    sw_raw_in     = 8'hFF;
    sw_clear_in   = '0;
    model_reset();
    #1;
    check_zero("rst_hold");

    // 1: reset with all switches on, then release
    for (int c = 0; c < 3; c++) cycle(8'hFF, 8'h00);
    #1 reset_reset_n = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cycle(8'hFF, 8'h00);
      check_eq("pwr_clean", 32'(sw_clean_out), (c >= 6) ? 32'hFF : 32'h0);
      check_eq("pwr_nochg", 32'(sw_changed_out), 32'h0);
      check_eq("pwr_valid", 32'(sw_valid_out), (c >= 7) ? 32'd1 : 32'd0);
    end

    // 2: clean step on bit 3 (also repeats without the sticky macro)
    for (int c = 0; c < 8; c++) cycle(8'hF7, 8'h00);
    cycle(8'hF7, 8'hFF);
    for (int c = 0; c < 2; c++) cycle(8'hF7, 8'h00);
    check_eq("step_sticky_clr", 32'(sw_sticky_out), 32'h0);
    for (int c = 1; c <= 8; c++) begin
      cycle(8'hFF, 8'h00);
      check_eq("step_changed", 32'(sw_changed_out), (c == 6) ? 32'h08 : 32'h0);
      check_eq("step_clean3", 32'(sw_clean_out[3]), (c >= 6) ? 32'd1 : 32'd0);
      check_eq("step_sticky", 32'(sw_sticky_out), (STICKY && c >= 6) ? 32'h08 : 32'h0);
    end

    // 3: bounce on bit 0, then hold high
    for (int c = 0; c < 8; c++) cycle(8'hFE, 8'h00);
    strobes   = 0;
    strobe_at = -1;
    for (int i = 0; i < 22; i++) begin
      raw = (i < 10 && (i % 2 == 1)) ? 8'hFE : 8'hFF;
      cycle(raw, 8'h00);
      if (sw_changed_out[0]) begin
        strobes++;
        strobe_at = i;
      end
    end
    check_eq("bounce_strobes", 32'(strobes), 32'd1);
    check_eq("bounce_at", 32'(strobe_at), 32'd15);

    // 4: clear-all coincides with bit 5 set
    for (int c = 1; c <= 6; c++) cycle(8'hDF, (c == 6) ? 8'hFF : 8'h00);
    check_eq("coll_changed", 32'(sw_changed_out), 32'h20);
    check_eq("coll_sticky", 32'(sw_sticky_out), STICKY ? 32'h20 : 32'h0);
    cycle(8'hDF, 8'h00);

    // 5: asynchronous reset while bit 2 is counting
    cycle(8'hDB, 8'h00);
    cycle(8'hDB, 8'h00);
    cycle(8'hDB, 8'h00);
    #3 reset_reset_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    for (int c = 0; c < 3; c++) cycle(8'hDB, 8'h00);
    #1 reset_reset_n = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cycle(8'hDB, 8'h00);
      check_eq("rerst_clean", 32'(sw_clean_out), (c >= 6) ? 32'hDB : 32'h0);
      check_eq("rerst_nochg", 32'(sw_changed_out), 32'h0);
      check_eq("rerst_valid", 32'(sw_valid_out), (c >= 7) ? 32'd1 : 32'd0);
    end

    // Multi-bit simultaneous acceptance
    for (int c = 1; c <= 7; c++) begin
      cycle(8'h24, 8'h00);
      if (c == 6) check_eq("multi_changed", 32'(sw_changed_out), 32'hFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
